vga_fb_scanout: RTL and testbench

//  Wishbone read-master framebuffer scanout for the 1024x768@60 VGA path on wb_clk_i (65 MHz pixel clock).

---
 rtl/vga_fb_scanout.sv | 198 +++++++++++++++++++
 tb/tb_vga_fb_scanout.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scanout.sv
// Wishbone read-master framebuffer scanout: prefetches 1bpp words into a FIFO and
// serialises them MSB-first onto pixel_o alongside registered VGA sync timing.
module vga_fb_scanout #(
  parameter int H_ACTIVE   = 1024,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 160,
  parameter int V_ACTIVE   = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 29,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        enable_i,
  input  logic [31:0] fb_base_i,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        pixel_o,
  output logic        frame_o,
  output logic        underflow_o,
  output logic        bus_err_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int WORDS   = H_ACTIVE * V_ACTIVE / 32;
  localparam int WCW     = $clog2(WORDS + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam logic [31:0] HS_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END = 32'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, v_last, frame_start, active, pop_slot, hs_on, vs_on;

  assign h_last      = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last      = (v_cnt == VW'(V_TOTAL - 1));
  assign frame_start = (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE));
  assign active      = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign pop_slot    = active && (h_cnt[4:0] == 5'd0);
  assign hs_on       = (32'(h_cnt) >= HS_BEG) && (32'(h_cnt) < HS_END);
  assign vs_on       = (32'(v_cnt) >= VS_BEG) && (32'(v_cnt) < VS_END);

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Fetch side: single classic read cycles into the word FIFO
  state_t         state, state_nx;
  logic           en_lat, discard, done, accept, room, more;
  logic [31:0]    fetch_addr;
  logic [WCW-1:0] word_cnt;
  logic [AW:0]    fifo_cnt;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [31:0]    fifo_mem [FIFO_DEPTH];
  logic           push, pop, fifo_empty;
  logic [31:0]    push_data, load_word, shreg;

  assign done       = wb_ack_i || wb_err_i;
  assign room       = fifo_cnt < (AW+1)'(FIFO_DEPTH);
  assign more       = word_cnt < WCW'(WORDS);
  assign accept     = (state == REQ) && done && !discard && !frame_start;
  assign push       = accept;
  assign push_data  = wb_err_i ? 32'h0 : wb_dat_i;
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = pop_slot && en_lat && !fifo_empty;
  assign load_word  = pop ? fifo_mem[rd_ptr] : 32'h0;

  assign wb_adr_o = fetch_addr;
  assign wb_sel_o = 4'hF;
  assign wb_we_o  = 1'b0;

  always_comb begin
    state_nx = state;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    case (state)
      IDLE: if (en_lat && room && more && !frame_start) state_nx = REQ;
      REQ: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        if (done) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      en_lat      <= 1'b0;
      fetch_addr  <= '0;
      word_cnt    <= '0;
      discard     <= 1'b0;
      underflow_o <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      state <= state_nx;
      if (frame_start) begin
        en_lat      <= enable_i;
        fetch_addr  <= fb_base_i;
        word_cnt    <= '0;
        // A cycle still in flight belongs to the old frame; let it finish, drop its data.
        discard     <= (state == REQ) && !done;
        underflow_o <= 1'b0;
        bus_err_o   <= 1'b0;
      end else begin
        if ((state == REQ) && done) discard <= 1'b0;
        if (accept) begin
          fetch_addr <= fetch_addr + 32'd4;
          word_cnt   <= word_cnt + 1'b1;
          if (wb_err_i) bus_err_o <= 1'b1;
        end
        if (pop_slot && en_lat && fifo_empty) underflow_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (frame_start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  // Video output stage: everything here is one cycle behind (h_cnt, v_cnt)
  always_ff @(posedge wb_clk_i) begin
    if (pop_slot) shreg <= {load_word[30:0], 1'b0};
    else          shreg <= {shreg[30:0], 1'b0};
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
      frame_o <= 1'b0;
      pixel_o <= 1'b0;
    end else begin
      hsync_o <= !hs_on;
      vsync_o <= !vs_on;
      frame_o <= frame_start;
      if (!active)       pixel_o <= 1'b0;
      else if (pop_slot) pixel_o <= load_word[31];
      else               pixel_o <= shreg[31] && en_lat;
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout at reduced timing: per-frame scenario table, Wishbone slave
// model with an address scoreboard, and an independent raster model for sync/pixel.
module tb_vga_fb_scanout;

  localparam int H_ACTIVE = 32, H_FP = 2, H_SYNC = 4, H_BP = 2;
  localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int H_TOTAL = 40, V_TOTAL = 7, NSC = 6;
  localparam logic [31:0] W0 = 32'h80000001, W1 = 32'hFFFF0000;
  localparam logic [31:0] W2 = 32'h0F0F55AA, W3 = 32'hC3A51234;
  localparam logic [31:0] NO_ERR = 32'hFFFF_FFFF;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [31:0] base = '0, adr, dat = '0;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack = 1'b0, err = 1'b0;
  logic        hsync, vsync, pixel, frame, underflow, bus_err;

  always #5 clk = ~clk;

  vga_fb_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .FIFO_DEPTH(4)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .enable_i(enable), .fb_base_i(base),
    .wb_adr_o(adr), .wb_sel_o(sel), .wb_we_o(we), .wb_cyc_o(cyc), .wb_stb_o(stb),
    .wb_dat_i(dat), .wb_ack_i(ack), .wb_err_i(err),
    .hsync_o(hsync), .vsync_o(vsync), .pixel_o(pixel), .frame_o(frame),
    .underflow_o(underflow), .bus_err_o(bus_err)
  );

  typedef struct packed {
    int              lat;
    bit              en;
    logic [31:0]     base;
    logic [31:0]     err_adr;
    bit              exp_uf;
    bit              exp_be;
    bit              full;
    logic [3:0][31:0] line;
  } sc_t;

  sc_t         sc [NSC];
  int          total = 0, bad = 0;
  int          oh = 0, ov = 0, cur = -1, w = 0, lat_cur = 0, nocyc = 0;
  logic [31:0] err_cur = NO_ERR;
  logic [31:0] q [$];
  bit          synced = 0, done = 0, stale = 0, got = 0, seen_frame = 0;
  logic        exp_px;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return W0;
      2'd1:    return W1;
      2'd2:    return W2;
      default: return W3;
    endcase
  endfunction

  task automatic set_sc(input int i, input int lat, input bit en, input logic [31:0] b,
                        input logic [31:0] ea, input bit uf, input bit be, input bit full,
                        input logic [31:0] l0, input logic [31:0] l1,
                        input logic [31:0] l2, input logic [31:0] l3);
    sc[i].lat = lat; sc[i].en = en; sc[i].base = b; sc[i].err_adr = ea;
    sc[i].exp_uf = uf; sc[i].exp_be = be; sc[i].full = full;
    sc[i].line[0] = l0; sc[i].line[1] = l1; sc[i].line[2] = l2; sc[i].line[3] = l3;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (sc=%0d h=%0d v=%0d): got %h want %h", name, cur, oh, ov, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Wishbone slave with programmable ack latency; acked addresses go through the scoreboard.
  task automatic slave_step(input bit use_sb);
    logic [31:0] e;
    ack = 1'b0;
    err = 1'b0;
    if (cyc && stb) begin
      if (w >= lat_cur) begin
        if (adr == err_cur) err = 1'b1;
        else begin
          ack = 1'b1;
          dat = mem_word(adr);
        end
        if (stale) stale = 0;
        else if (use_sb) begin
          if (q.size() == 0) check("sb_extra_read", adr, 32'hDEAD_DEAD);
          else begin
            e = q.pop_front();
            check("sb_adr", adr, e);
          end
        end
        w = 0;
      end else begin
        w++;
      end
    end else begin
      w = 0;
    end
  endtask

  initial begin
    set_sc(0, 0,   1, 32'h1000, NO_ERR,      0, 0, 1, W0, W1, W2, W3);
    set_sc(1, 0,   1, 32'h2000, 32'h2008,    0, 1, 1, W0, W1, 32'h0, W3);
    set_sc(2, 100, 1, 32'h3000, NO_ERR,      1, 0, 0, W0, 32'h0, 32'h0, W1);
    set_sc(3, 0,   1, 32'h4000, NO_ERR,      0, 0, 1, W0, W1, W2, W3);
    set_sc(4, 0,   0, 32'h5000, NO_ERR,      0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0);
    set_sc(5, 3,   1, 32'h6000, NO_ERR,      0, 0, 1, W0, W1, W2, W3);

    enable = sc[0].en;
    base   = sc[0].base;
    repeat (3) @(negedge clk);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_pixel", pixel, 0);
    check("rst_frame", frame, 0);
    check("rst_underflow", underflow, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_adr", adr, 0);
    check("rst_we", we, 0);
    check("rst_sel", sel, 4'hF);
    rst_n = 1'b1;

    for (int t = 0; t < 4000 && !done; t++) begin
      @(negedge clk);
      if (!synced) begin
        if (frame) begin
          synced = 1;
          oh = 0;
          ov = V_ACTIVE;
        end else if (t == 400) begin
          fail_now("first_frame");
          done = 1;
        end
      end else begin
        oh++;
        if (oh == H_TOTAL) begin
          oh = 0;
          ov = (ov + 1) % V_TOTAL;
        end
      end
      if (synced && !done) begin
        if (oh == 0 && ov == V_ACTIVE) begin
          if (cur >= 0 && sc[cur].full) check("sb_all_fetched", 32'(q.size()), 0);
          cur++;
          if (cur == NSC) done = 1;
          else begin
            lat_cur = sc[cur].lat;
            err_cur = sc[cur].err_adr;
            q.delete();
            if (sc[cur].en)
              for (int k = 0; k < 4; k++) q.push_back(sc[cur].base + 32'(4 * k));
            stale = cyc;
            nocyc = 0;
            check("underflow_cleared", underflow, 0);
            check("bus_err_cleared", bus_err, 0);
          end
        end
        if (!done) begin
          if (oh == 0 && ov == V_ACTIVE - 1 && cur + 1 < NSC) begin
            enable = sc[cur + 1].en;
            base   = sc[cur + 1].base;
          end
          if (!sc[cur].en && cyc && !stale) nocyc++;
          if (oh == H_TOTAL - 1 && ov == V_ACTIVE - 1) begin
            check("underflow_end", underflow, sc[cur].exp_uf);
            check("bus_err_end", bus_err, sc[cur].exp_be);
            if (!sc[cur].en) check("no_cyc_disabled", nocyc, 0);
          end
          exp_px = (ov < V_ACTIVE && oh < H_ACTIVE) ? sc[cur].line[ov][31 - oh] : 1'b0;
          check("hsync", hsync, !(oh >= H_ACTIVE + H_FP && oh < H_ACTIVE + H_FP + H_SYNC));
          check("vsync", vsync, !(ov >= V_ACTIVE + V_FP && ov < V_ACTIVE + V_FP + V_SYNC));
          check("frame", frame, (oh == 0 && ov == V_ACTIVE));
          check("pixel", pixel, exp_px);
        end
      end
      if (!done) slave_step(synced);
    end
    if (!done) fail_now("frame_budget");

    if (cur == NSC) begin
      // Hold a read open with a slow slave, then pull reset in the middle of it.
      lat_cur = 60;
      err_cur = NO_ERR;
      got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        slave_step(0);
        if (cyc) got = 1;
      end
      if (!got) fail_now("req_start");
      repeat (5) begin
        @(negedge clk);
        slave_step(0);
      end
      check("cyc_held", cyc, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_cyc", cyc, 0);
      check("async_rst_stb", stb, 0);
      check("async_rst_hsync", hsync, 1);
      ack = 1'b0;
      err = 1'b0;
      base = 32'h7000;
      enable = 1'b1;
      lat_cur = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      got = 0;
      seen_frame = 0;
      for (int t = 0; t < 600 && !got; t++) begin
        @(negedge clk);
        if (frame) seen_frame = 1;
        if (cyc) got = 1;
      end
      if (!got) fail_now("post_reset_fetch");
      else begin
        check("post_reset_adr", adr, 32'h7000);
        check("frame_before_fetch", seen_frame, 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
